// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays short square-wave jingles for jump, game start and
// game over. Note pitch is a half-period divider in clk cycles; note length
// is counted in 60 Hz game ticks.
//
// Ports:
//   clk              system (pixel) clock
//   rst_n            synchronous active-low reset
//   game_tick        one-cycle 60 Hz pulse, advances note timing
//   game_start_pulse one-cycle request for the start jingle
//   jump_pulse       one-cycle request for the jump chirp
//   game_over_pulse  one-cycle request for the game-over jingle
//   mute             level; forces sound low without stopping sequencing
//   sound            registered square-wave audio output
//   busy             high while an effect plays
//   cur_effect       00 none, 01 jump, 10 start, 11 game over
//
// state | meaning
// IDLE  | silent, waiting for a request
// PLAY  | stepping through the active effect's note table
module sfx_sequencer #(
    parameter int CLK_HZ = 25175000,
    parameter int DIV_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_tick,
    input  logic       game_start_pulse,
    input  logic       jump_pulse,
    input  logic       game_over_pulse,
    input  logic       mute,
    output logic       sound,
    output logic       busy,
    output logic [1:0] cur_effect
);

    localparam int HP_392  = CLK_HZ / (2 * 392);
    localparam int HP_523  = CLK_HZ / (2 * 523);
    localparam int HP_659  = CLK_HZ / (2 * 659);
    localparam int HP_784  = CLK_HZ / (2 * 784);
    localparam int HP_880  = CLK_HZ / (2 * 880);
    localparam int HP_1320 = CLK_HZ / (2 * 1320);

    // Encoding doubles as priority: a larger code wins.
    localparam logic [1:0] FX_NONE  = 2'd0;
    localparam logic [1:0] FX_JUMP  = 2'd1;
    localparam logic [1:0] FX_START = 2'd2;
    localparam logic [1:0] FX_OVER  = 2'd3;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state, state_nxt;
    logic [1:0]         effect, effect_nxt;
    logic [1:0]         note_idx, note_idx_nxt;
    logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
    logic [3:0]         tick_cnt, tick_cnt_nxt;
    logic               tone, tone_nxt;
    logic               sound_nxt;
    logic [1:0]         req_fx;
    logic               load;
    logic [4:0]         tick_inc;
    logic [DIV_W-1:0]   hp;
    logic [4:0]         dur;
    logic [1:0]         last_idx;

    function automatic logic [DIV_W-1:0] note_hp(input logic [1:0] fx, input logic [1:0] idx);
        logic [DIV_W-1:0] h;
        h = DIV_W'(HP_880);
        case (fx)
            FX_JUMP:  h = (idx == 2'd0) ? DIV_W'(HP_880) : DIV_W'(HP_1320);
            FX_START: case (idx)
                          2'd0:    h = DIV_W'(HP_523);
                          2'd1:    h = DIV_W'(HP_659);
                          default: h = DIV_W'(HP_784);
                      endcase
            FX_OVER:  case (idx)
                          2'd0:    h = DIV_W'(HP_784);
                          2'd1:    h = DIV_W'(HP_659);
                          2'd2:    h = DIV_W'(HP_523);
                          default: h = DIV_W'(HP_392);
                      endcase
            default:  h = DIV_W'(HP_880);
        endcase
        return h;
    endfunction

    function automatic logic [4:0] note_dur(input logic [1:0] fx, input logic [1:0] idx);
        logic [4:0] d;
        case (fx)
            FX_JUMP:  d = 5'd3;
            FX_START: d = 5'd6;
            FX_OVER:  d = (idx == 2'd3) ? 5'd16 : 5'd8;
            default:  d = 5'd1;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] note_last(input logic [1:0] fx);
        logic [1:0] l;
        case (fx)
            FX_JUMP:  l = 2'd1;
            FX_START: l = 2'd2;
            FX_OVER:  l = 2'd3;
            default:  l = 2'd0;
        endcase
        return l;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            effect   <= FX_NONE;
            note_idx <= '0;
            div_cnt  <= '0;
            tick_cnt <= '0;
            tone     <= 1'b0;
            sound    <= 1'b0;
        end else begin
            state    <= state_nxt;
            effect   <= effect_nxt;
            note_idx <= note_idx_nxt;
            div_cnt  <= div_cnt_nxt;
            tick_cnt <= tick_cnt_nxt;
            tone     <= tone_nxt;
            sound    <= sound_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        effect_nxt   = effect;
        note_idx_nxt = note_idx;
        div_cnt_nxt  = div_cnt;
        tick_cnt_nxt = tick_cnt;
        tone_nxt     = tone;

        if (game_over_pulse)       req_fx = FX_OVER;
        else if (game_start_pulse) req_fx = FX_START;
        else if (jump_pulse)       req_fx = FX_JUMP;
        else                       req_fx = FX_NONE;

        // In IDLE effect is FX_NONE, so any request loads.
        load     = (req_fx != FX_NONE) && (req_fx >= effect);
        hp       = note_hp(effect, note_idx);
        dur      = note_dur(effect, note_idx);
        last_idx = note_last(effect);
        tick_inc = {1'b0, tick_cnt} + 5'd1;

        if (load) begin
            // A trigger swallows a coincident game_tick.
            state_nxt    = PLAY;
            effect_nxt   = req_fx;
            note_idx_nxt = '0;
            div_cnt_nxt  = '0;
            tick_cnt_nxt = '0;
            tone_nxt     = 1'b0;
        end else if (state == PLAY) begin
            if (div_cnt == hp - DIV_W'(1)) begin
                div_cnt_nxt = '0;
                tone_nxt    = ~tone;
            end else begin
                div_cnt_nxt = div_cnt + DIV_W'(1);
            end
            if (game_tick) begin
                if (tick_inc == dur) begin
                    tick_cnt_nxt = '0;
                    div_cnt_nxt  = '0;
                    tone_nxt     = 1'b0;
                    if (note_idx == last_idx) begin
                        state_nxt    = IDLE;
                        effect_nxt   = FX_NONE;
                        note_idx_nxt = '0;
                    end else begin
                        note_idx_nxt = note_idx + 2'd1;
                    end
                end else begin
                    tick_cnt_nxt = tick_inc[3:0];
                end
            end
        end else begin
            tone_nxt = 1'b0;
        end

        // Registered from the next tone so the first rising edge lands HP
        // cycles after load, while mute still lags its input by one cycle.
        sound_nxt = tone_nxt & ~mute;
    end

    assign busy       = (state == PLAY);
    assign cur_effect = effect;

endmodule

// File: tb/tb_sfx_sequencer.sv
module tb_sfx_sequencer;

    // Scaled clock so half-periods are tens of cycles and runs stay short.
    localparam int CLK_HZ   = 40000;
    localparam int DIV_W    = 16;
    localparam int TICK_DIV = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       game_tick;
    logic       game_start_pulse;
    logic       jump_pulse;
    logic       game_over_pulse;
    logic       mute;
    logic       sound;
    logic       busy;
    logic [1:0] cur_effect;

    always #5 clk = ~clk;

    sfx_sequencer #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .game_tick        (game_tick),
        .game_start_pulse (game_start_pulse),
        .jump_pulse       (jump_pulse),
        .game_over_pulse  (game_over_pulse),
        .mute             (mute),
        .sound            (sound),
        .busy             (busy),
        .cur_effect       (cur_effect)
    );

    typedef struct {
        logic       snd;
        logic       bsy;
        logic [1:0] fx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tick_phase = 0;

    // Reference model: which effect plays, which note, cycles since the note
    // began, and ticks counted in that note.
    bit m_act = 1'b0;
    int m_fx = 0, m_note = 0, m_k = 0, m_ticks = 0;

    function automatic int freq_of(input int fx, input int n);
        int f;
        f = 880;
        case (fx)
            1: f = (n == 0) ? 880 : 1320;
            2: f = (n == 0) ? 523 : (n == 1) ? 659 : 784;
            3: f = (n == 0) ? 784 : (n == 1) ? 659 : (n == 2) ? 523 : 392;
            default: f = 880;
        endcase
        return f;
    endfunction

    function automatic int dur_of(input int fx, input int n);
        if (fx == 1) return 3;
        if (fx == 2) return 6;
        return (n == 3) ? 16 : 8;
    endfunction

    function automatic int notes_of(input int fx);
        return (fx == 1) ? 2 : (fx == 2) ? 3 : 4;
    endfunction

    function automatic int hp_of(input int fx, input int n);
        return CLK_HZ / (2 * freq_of(fx, n));
    endfunction

    task automatic model_edge();
        int   req;
        exp_t e;
        req = game_over_pulse ? 3 : game_start_pulse ? 2 : jump_pulse ? 1 : 0;
        if (!rst_n) begin
            m_act = 1'b0;
        end else if (req != 0 && (!m_act || req >= m_fx)) begin
            m_act = 1'b1; m_fx = req; m_note = 0; m_k = 0; m_ticks = 0;
        end else if (m_act) begin
            m_k++;
            if (game_tick) begin
                m_ticks++;
                if (m_ticks == dur_of(m_fx, m_note)) begin
                    m_note++; m_k = 0; m_ticks = 0;
                    if (m_note == notes_of(m_fx)) m_act = 1'b0;
                end
            end
        end
        e.bsy = m_act;
        e.fx  = m_act ? 2'(m_fx) : 2'd0;
        e.snd = m_act && (((m_k / hp_of(m_fx, m_note)) % 2) == 1) && !mute;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sound", int'(sound), int'(e.snd));
                check("busy", int'(busy), int'(e.bsy));
                check("cur_effect", int'(cur_effect), int'(e.fx));
            end
        end
    end

    // Called at the falling edge: drive inputs, take one rising edge.
    task automatic step(input bit t, input bit j, input bit s, input bit o);
        game_tick        = t;
        jump_pulse       = j;
        game_start_pulse = s;
        game_over_pulse  = o;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        game_tick = 0; jump_pulse = 0; game_start_pulse = 0; game_over_pulse = 0;
    endtask

    task automatic next_tick(output bit t);
        t = (tick_phase == TICK_DIV - 1);
        tick_phase = t ? 0 : tick_phase + 1;
    endtask

    task automatic trig(input bit j, input bit s, input bit o);
        bit t;
        next_tick(t);
        step(t, j, s, o);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) trig(0, 0, 0);
    endtask

    initial begin : stim
        bit t;
        rst_n = 0; mute = 0;
        game_tick = 0; jump_pulse = 0; game_start_pulse = 0; game_over_pulse = 0;
        @(negedge clk);

        // Reset held with a jump request present.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        rst_n = 1;
        run(10);

        // Jump chirp, then priority with coincident jump + game over.
        trig(1, 0, 0);
        run(300);
        trig(1, 0, 1);
        run(1700);

        // Game over ignores jump; start is preempted by game over.
        trig(0, 0, 1);
        run(100);
        trig(1, 0, 0);
        run(1700);
        trig(0, 1, 0);
        run(150);
        trig(0, 0, 1);
        run(1700);

        // Jump restarts itself.
        trig(1, 0, 0);
        run(60);
        trig(1, 0, 0);
        run(300);

        // Mute during start jingle.
        trig(0, 1, 0);
        run(100);
        mute = 1;
        run(700);
        mute = 0;
        run(50);

        // Tick coincident with start is not counted.
        tick_phase = TICK_DIV - 1;
        trig(0, 1, 0);
        run(800);

        // Reset in the middle of game over.
        trig(0, 0, 1);
        run(700);
        rst_n = 0;
        step(0, 0, 0, 0);
        rst_n = 1;
        run(20);

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 299) == 0) mute = ~mute;
            rst_n = ($urandom_range(0, 1999) != 0);
            t = ($urandom_range(0, 29) == 0);
            step(t, $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 399) == 0);
        end
        rst_n = 1; mute = 0;
        run(5);

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
